// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: PC sequencer feeding a 2-entry prefetch buffer from an async-read instruction ROM.
module inst_fetch_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    output logic [ADDR_W-1:0]   Inst_addr,
    input  logic [DATA_W-1:0]   Inst_code,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [DATA_W-1:0]   inst_out,
    output logic [ADDR_W+1:0]   inst_pc,
    output logic                running,
    output logic [15:0]         fetch_count
);
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;
    logic              state;
    logic [ADDR_W-1:0] pc, p0, p1;
    logic [DATA_W-1:0] d0, d1;
    logic [1:0]        count, left;
    logic              deq, enq;
    assign Inst_addr  = pc;
    assign running    = state;
    assign inst_valid = count != 2'd0;
    assign inst_out   = d0;
    assign inst_pc    = {p0, 2'b00};
    assign deq        = inst_valid & inst_ready;
    assign enq        = (state == RUN) & ~stop & ~redirect_valid & (count < 2'd2 | deq);
    assign left       = count - {1'b0, deq};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            count       <= '0;
            d0          <= '0;
            d1          <= '0;
            p0          <= '0;
            p1          <= '0;
            fetch_count <= '0;
        end else begin
            state <= stop ? IDLE : (start ? RUN : state);
            if (redirect_valid) begin
                pc    <= redirect_addr;
                count <= '0;
            end else begin
                count <= left + {1'b0, enq};
                if (deq) begin
                    d0 <= d1;
                    p0 <= p1;
                end
                // the new entry lands in the first slot left free after this cycle's dequeue
                if (enq) begin
                    pc          <= pc + 1'b1;
                    fetch_count <= fetch_count + 16'd1;
                    if (left == 2'd0) begin
                        d0 <= Inst_code;
                        p0 <= pc;
                    end else begin
                        d1 <= Inst_code;
                        p1 <= pc;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: table vectors, directed corner sequences and random traffic against a queue model.
module tb_inst_fetch_ctrl;
    logic        clk = 0, rst = 1, start = 0, stop = 0;
    logic [5:0]  Inst_addr;
    logic [31:0] Inst_code;
    logic        redirect_valid = 0;
    logic [5:0]  redirect_addr = 0;
    logic        inst_valid, inst_ready = 0;
    logic [31:0] inst_out;
    logic [7:0]  inst_pc;
    logic        running;
    logic [15:0] fetch_count;
    logic [31:0] rom [64];
    int checks = 0, errors = 0;

    typedef struct { logic [5:0] pc; logic [31:0] d; } ent_t;
    ent_t q[$];
    int  m_pc = 0, m_fc = 0;
    bit  m_run = 0;

    typedef struct {
        logic start, stop, ready;
        logic e_valid; logic [7:0] e_pc; logic [5:0] e_addr; logic [15:0] e_fc; logic e_run;
    } vec_t;
    vec_t vt[11];

    inst_fetch_ctrl #(.ADDR_W(6), .DATA_W(32), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .Inst_addr(Inst_addr), .Inst_code(Inst_code),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc),
        .running(running), .fetch_count(fetch_count)
    );

    assign Inst_code = rom[Inst_addr];
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic r, input logic v,
                                input logic [7:0] pcb, input logic [5:0] a, input logic [15:0] f, input logic run);
        vec_t x;
        x.start = s; x.stop = p; x.ready = r; x.e_valid = v;
        x.e_pc = pcb; x.e_addr = a; x.e_fc = f; x.e_run = run;
        return x;
    endfunction

    // one clock: advance the model from the spec's enqueue/dequeue rules, then compare everything
    task automatic step();
        bit   d, e;
        ent_t n;
        d = q.size() > 0 && inst_ready;
        e = m_run && !stop && !redirect_valid && (q.size() < 2 || d);
        n.pc = 6'(m_pc);
        n.d  = rom[m_pc];
        @(posedge clk);
        if (d) void'(q.pop_front());
        if (redirect_valid) begin
            q.delete();
            m_pc = int'(redirect_addr);
        end else if (e) begin
            q.push_back(n);
            m_pc = (m_pc + 1) % 64;
            m_fc = (m_fc + 1) % 65536;
        end
        if (stop) m_run = 0; else if (start) m_run = 1;
        #1;
        chk("valid", inst_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("inst_out", inst_out, q[0].d);
            chk("inst_pc", inst_pc, {q[0].pc, 2'b00});
        end
        chk("inst_addr", Inst_addr, m_pc);
        chk("running", running, m_run);
        chk("fetch_count", fetch_count, m_fc);
        start = 0; stop = 0; redirect_valid = 0;
    endtask

    initial begin
        bit found;
        int frozen;
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        vt[0]  = mk(1, 0, 1, 0, 8'h00, 0, 0, 1);
        vt[1]  = mk(0, 0, 1, 1, 8'h00, 1, 1, 1);
        vt[2]  = mk(0, 0, 1, 1, 8'h04, 2, 2, 1);
        vt[3]  = mk(0, 0, 1, 1, 8'h08, 3, 3, 1);
        vt[4]  = mk(0, 0, 0, 1, 8'h08, 4, 4, 1);
        vt[5]  = mk(0, 0, 0, 1, 8'h08, 4, 4, 1);
        vt[6]  = mk(0, 0, 0, 1, 8'h08, 4, 4, 1);
        vt[7]  = mk(0, 0, 0, 1, 8'h08, 4, 4, 1);
        vt[8]  = mk(0, 0, 0, 1, 8'h08, 4, 4, 1);
        vt[9]  = mk(0, 0, 1, 1, 8'h0C, 5, 5, 1);
        vt[10] = mk(0, 0, 1, 1, 8'h10, 6, 6, 1);

        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_valid", inst_valid, 0);
        chk("rst_out", inst_out, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_running", running, 0);
        chk("rst_fc", fetch_count, 0);
        chk("rst_addr", Inst_addr, 0);

        for (int i = 0; i < 11; i++) begin
            start = vt[i].start; stop = vt[i].stop; inst_ready = vt[i].ready;
            step();
            chk("vec_valid", inst_valid, vt[i].e_valid);
            if (vt[i].e_valid) begin
                chk("vec_pc", inst_pc, vt[i].e_pc);
                chk("vec_out", inst_out, 32'h1000_0000 + 32'(vt[i].e_pc >> 2));
            end
            chk("vec_addr", Inst_addr, vt[i].e_addr);
            chk("vec_fc", fetch_count, vt[i].e_fc);
            chk("vec_run", running, vt[i].e_run);
        end

        found = 0;
        inst_ready = 1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (inst_valid && inst_pc == 8'hFC) begin found = 1; break; end
        end
        chk("wrap_reached", found, 1);
        step();
        chk("wrap_pc", inst_pc, 8'h00);
        chk("wrap_out", inst_out, 32'h1000_0000);

        inst_ready = 0;
        step(); step();
        inst_ready = 1; redirect_valid = 1; redirect_addr = 6'd20;
        step();
        chk("redir_valid0", inst_valid, 0);
        chk("redir_addr", Inst_addr, 20);
        step();
        chk("redir_valid1", inst_valid, 1);
        chk("redir_pc", inst_pc, 8'h50);
        chk("redir_out", inst_out, 32'h1000_0014);

        stop = 1; step();
        chk("stop_run", running, 0);
        step(); step();
        chk("drained", inst_valid, 0);
        start = 1; stop = 1; step();
        chk("startstop_idle", running, 0);
        start = 1; step();
        chk("start_run", running, 1);
        inst_ready = 0; step();
        stop = 1; step();
        frozen = m_pc;
        chk("stop_run2", running, 0);
        chk("stop_hold_valid", inst_valid, 1);
        inst_ready = 1; step();
        chk("stop_drain", inst_valid, 0);
        step(); step();
        chk("stop_frozen", Inst_addr, frozen);
        start = 1; step();
        step();
        chk("resume_valid", inst_valid, 1);
        chk("resume_pc", inst_pc, 8'(frozen * 4));

        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 19) == 0);
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_addr = 6'($urandom_range(0, 63));
            step();
        end

        start = 1; step();
        inst_ready = 1; step(); step();
        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_out", inst_out, 0);
        chk("arst_pc", inst_pc, 0);
        chk("arst_run", running, 0);
        chk("arst_fc", fetch_count, 0);
        chk("arst_addr", Inst_addr, 0);
        @(posedge clk);
        #1 rst = 0;
        q.delete(); m_pc = 0; m_run = 0; m_fc = 0;
        start = 1; step();
        step();
        chk("restart_valid", inst_valid, 1);
        chk("restart_pc", inst_pc, 0);
        chk("restart_out", inst_out, 32'h1000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
